// File: rtl/root_arbiter.sv
// root_arbiter
//   Round-robin sequencer that shares one Goldschmidt square-root unit among
//   N requesters. It latches the winner's radicand, pulses rt_start, waits
//   for a fresh rt_ready, captures rt_q and returns it with a one-cycle ack.
//   A watchdog aborts an operation that never completes with a one-cycle err.
//
// Ports
//   clk, clr     rising-edge clock, synchronous active-high reset
//   req[N]       request level per requester
//   d_in[32*N]   radicands, requester i at [32i+31:32i]
//   ack[N]       one-cycle pulse: q_out holds requester's result
//   err[N]       one-cycle pulse: requester's operation timed out
//   q_out[32]    result register, holds until the next capture
//   gnt_id[3]    index of the current/last granted requester
//   arb_busy     high in every state except IDLE
//   rt_d[32]     registered radicand to the root unit
//   rt_start     start pulse to the root unit
//   rt_busy      root unit busy (informational only)
//   rt_ready     root unit result ready
//   rt_q[32]     root unit result
//   dbg_state[3] current FSM state encoding
//
// Requester handshake: a requester raises req[i] with d_in[i] stable and
// holds both until it sees ack[i] or err[i]; exactly one of those pulses
// once per granted operation, and dropping req[i] after the grant does not
// cancel the operation already issued.

module root_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [N-1:0]    req,
    input  logic [32*N-1:0] d_in,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    err,
    output logic [31:0]     q_out,
    output logic [2:0]      gnt_id,
    output logic            arb_busy,
    output logic [31:0]     rt_d,
    output logic            rt_start,
    input  logic            rt_busy,
    input  logic            rt_ready,
    input  logic [31:0]     rt_q,
    output logic [2:0]      dbg_state
);

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        FAIL  = 3'd4
    } state_t;

    state_t        state, nxt;
    logic [2:0]    ptr;
    logic [WW-1:0] wcnt;

    // Grant search results.
    logic          hi_hit;
    logic [2:0]    hi_idx;
    logic [2:0]    lo_idx;
    logic [2:0]    gnt_sel;
    logic [31:0]   d_sel;
    logic [2:0]    next_ptr;

    // The root unit never gets restarted outside ISSUE, so its busy flag
    // carries no information the sequencer needs.
    logic unused_busy;
    assign unused_busy = rt_busy;

    assign dbg_state = state;

    // Round-robin pick: lowest set bit at or above ptr, otherwise the lowest
    // set bit overall (which is then below ptr, i.e. the wrap-around case).
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo_idx = 3'(k);
                if (3'(k) >= ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = 3'(k);
                end
            end
        end
        gnt_sel = hi_hit ? hi_idx : lo_idx;
        d_sel   = '0;
        for (int k = 0; k < N; k++) begin
            if (3'(k) == gnt_sel) d_sel = d_in[32*k +: 32];
        end
    end

    assign next_ptr = (gnt_id == 3'(N - 1)) ? 3'd0 : gnt_id + 3'd1;

    // Next state and Moore outputs.
    always_comb begin
        nxt      = state;
        rt_start = 1'b0;
        ack      = '0;
        err      = '0;
        arb_busy = (state != IDLE);
        case (state)
            IDLE:  if (|req) nxt = ISSUE;
            ISSUE: begin
                rt_start = 1'b1;
                nxt      = WAIT;
            end
            WAIT: begin
                // A ready seen in the first WAIT cycle may be left over from
                // the previous operation, so it is not trusted.
                if ((wcnt != '0) && rt_ready) nxt = DONE;
                else if (wcnt == WW'(TIMEOUT - 1)) nxt = FAIL;
            end
            DONE: begin
                ack = ONE << gnt_id;
                nxt = IDLE;
            end
            FAIL: begin
                err = ONE << gnt_id;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt_id <= '0;
            rt_d   <= '0;
            q_out  <= '0;
            wcnt   <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_id <= gnt_sel;
                        rt_d   <= d_sel;
                        wcnt   <= '0;
                    end
                end
                WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    if ((wcnt != '0) && rt_ready) q_out <= rt_q;
                end
                DONE, FAIL: ptr <= next_ptr;
                default: ;
            endcase
        end
    end

endmodule
